// File: rtl/popcount_accum_neuron_pkg.sv
// Shared types for the popcount accumulate neuron: ternary output encoding,
// FSM state type and the signed accumulator width helper.
package popcount_pkg;

   typedef logic [1:0] trit_t;

   localparam trit_t TRIT_ZERO = 2'b00;
   localparam trit_t TRIT_POS  = 2'b01;
   localparam trit_t TRIT_NEG  = 2'b11;

   typedef enum logic [1:0] {
      ST_ACCUM = 2'd0,
      ST_DRAIN = 2'd1,
      ST_HOLD  = 2'd2
   } state_e;

   // One bit of headroom beyond the magnitude of a full group keeps the sum signed.
   function automatic int sum_width(input int width, input int beats);
      return $clog2(width * beats + 1) + 1;
   endfunction

endpackage

// File: rtl/popcount_accum_neuron_tree.sv
// Combinational popcount of one activation mask. Defining POPCNT_APPROX_EN
// drops the count LSB (count & ~1) to trade one unit of accuracy for a cheaper adder.
module popcount_tree #(
   parameter int WIDTH = 16,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] vec_i,
   output logic [CNT_W-1:0] cnt_o
);

   always_comb begin
      cnt_o = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_o = cnt_o + CNT_W'(vec_i[i]);
      end
`ifdef POPCNT_APPROX_EN
      cnt_o[0] = 1'b0;
`endif
   end

endmodule

// File: rtl/popcount_accum_neuron.sv
// Ternary neuron: accumulates popcount(pos)-popcount(neg) over BEATS beats and
// thresholds the group sum. Optional build macro: POPCNT_APPROX_EN (see popcount_tree).
module popcount_accum_neuron
   import popcount_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int BEATS = 4,
   localparam int SUM_W = sum_width(WIDTH, BEATS)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [WIDTH-1:0]        in_pos,
   input  logic [WIDTH-1:0]        in_neg,
   input  logic signed [SUM_W-1:0] thr_hi,
   input  logic signed [SUM_W-1:0] thr_lo,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [1:0]              out_trit,
   output logic signed [SUM_W-1:0] out_sum,
   output logic [1:0]              dbg_state
);

   // Handshake rule on both sides: a transfer happens on a rising edge where
   // valid and ready are both high; nothing else moves data.

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

   logic [CNT_W-1:0]        pos_cnt, neg_cnt;
   logic signed [SUM_W-1:0] beat_d;

   state_e                  state_q, state_d;
   logic                    rdy_q, rdy_d;
   logic [BC_W-1:0]         in_cnt_q, in_cnt_d;
   logic                    s1_valid_q, s1_valid_d;
   logic signed [SUM_W-1:0] s1_q, s1_d;
   logic signed [SUM_W-1:0] acc_q, acc_d;
   logic signed [SUM_W-1:0] out_sum_q, out_sum_d;
   trit_t                   out_trit_q, out_trit_d;

   logic                    accept, last_beat, out_hs;
   logic signed [SUM_W-1:0] final_sum;

   popcount_tree #(.WIDTH(WIDTH)) u_pos_tree (.vec_i(in_pos), .cnt_o(pos_cnt));
   popcount_tree #(.WIDTH(WIDTH)) u_neg_tree (.vec_i(in_neg), .cnt_o(neg_cnt));

   assign beat_d    = $signed(SUM_W'(pos_cnt)) - $signed(SUM_W'(neg_cnt));
   assign accept    = in_valid & rdy_q;
   assign last_beat = (in_cnt_q == BC_W'(BEATS - 1));
   assign out_hs    = (state_q == ST_HOLD) & out_ready;
   assign final_sum = acc_q + s1_q;

   always_comb begin
      state_d    = state_q;
      in_cnt_d   = in_cnt_q;
      s1_valid_d = accept;
      s1_d       = s1_q;
      acc_d      = acc_q;
      out_sum_d  = out_sum_q;
      out_trit_d = out_trit_q;

      if (accept) begin
         s1_d = beat_d;
         if (!last_beat) begin
            in_cnt_d = in_cnt_q + BC_W'(1);
         end
      end

      if (s1_valid_q) begin
         acc_d = final_sum;
      end

      case (state_q)
         ST_ACCUM: begin
            if (accept && last_beat) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // The only stage-1 entry seen in DRAIN is the group's final beat.
            if (s1_valid_q) begin
               state_d   = ST_HOLD;
               out_sum_d = final_sum;
               if (final_sum >= thr_hi) begin
                  out_trit_d = TRIT_POS;
               end else if (final_sum <= thr_lo) begin
                  out_trit_d = TRIT_NEG;
               end else begin
                  out_trit_d = TRIT_ZERO;
               end
            end
         end
         ST_HOLD: begin
            if (out_hs) begin
               state_d  = ST_ACCUM;
               acc_d    = '0;
               in_cnt_d = '0;
            end
         end
         default: state_d = ST_ACCUM;
      endcase

      rdy_d = (state_d == ST_ACCUM);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_ACCUM;
         rdy_q      <= 1'b0;
         in_cnt_q   <= '0;
         s1_valid_q <= 1'b0;
         s1_q       <= '0;
         acc_q      <= '0;
         out_sum_q  <= '0;
         out_trit_q <= TRIT_ZERO;
      end else begin
         state_q    <= state_d;
         rdy_q      <= rdy_d;
         in_cnt_q   <= in_cnt_d;
         s1_valid_q <= s1_valid_d;
         s1_q       <= s1_d;
         acc_q      <= acc_d;
         out_sum_q  <= out_sum_d;
         out_trit_q <= out_trit_d;
      end
   end

   assign in_ready  = rdy_q;
   assign out_valid = (state_q == ST_HOLD);
   assign out_sum   = out_sum_q;
   assign out_trit  = out_trit_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_popcount_accum_neuron.sv
// Self-checking bench for popcount_accum_neuron (WIDTH=16, BEATS=4, thresholds +8/-8).
module tb_popcount_accum_neuron;

   localparam int WIDTH  = 16;
   localparam int BEATS  = 4;
   localparam int SUM_W  = popcount_pkg::sum_width(WIDTH, BEATS);
   localparam int THR_HI = 8;
   localparam int THR_LO = -8;
   localparam int GROUPS = 1000;

   typedef logic [WIDTH-1:0] beat_arr_t [BEATS];

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    in_valid;
   logic                    in_ready;
   logic [WIDTH-1:0]        in_pos, in_neg;
   logic signed [SUM_W-1:0] thr_hi, thr_lo;
   logic                    out_valid;
   logic                    out_ready;
   logic [1:0]              out_trit;
   logic signed [SUM_W-1:0] out_sum;
   logic [1:0]              dbg_state;

   logic [SUM_W+1:0] exp_q[$];
   int               tests_run = 0;
   int               tests_failed = 0;
   bit               abort = 1'b0;

   popcount_accum_neuron #(.WIDTH(WIDTH), .BEATS(BEATS)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pos(in_pos), .in_neg(in_neg),
      .thr_hi(thr_hi), .thr_lo(thr_lo),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_trit(out_trit), .out_sum(out_sum),
      .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic int beat_model(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] n);
      int cp, cn;
      cp = $countones(p);
      cn = $countones(n);
`ifdef POPCNT_APPROX_EN
      cp = cp & ~1;
      cn = cn & ~1;
`endif
      return cp - cn;
   endfunction

   function automatic logic [1:0] trit_model(input int s);
      if (s >= THR_HI) return 2'b01;
      if (s <= THR_LO) return 2'b11;
      return 2'b00;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive_beat(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] n);
      bit ok;
      if (abort) return;
      in_valid = 1'b1;
      in_pos   = p;
      in_neg   = n;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         if (ok) begin
            in_valid = 1'b0;
            in_pos   = WIDTH'($urandom);
            in_neg   = WIDTH'($urandom);
            return;
         end
      end
      in_valid = 1'b0;
      abort    = 1'b1;
      tests_run++;
      tests_failed++;
      $display("FAIL beat_accept: in_ready never high within 200 cycles (required 1)");
   endtask

   task automatic send_group(input beat_arr_t p, input beat_arr_t n, input int max_gap);
      int sum;
      sum = 0;
      for (int b = 0; b < BEATS; b++) begin
         repeat ($urandom_range(0, max_gap)) begin
            in_valid = 1'b0;
            in_pos   = WIDTH'($urandom);
            in_neg   = WIDTH'($urandom);
            @(posedge clk);
            #1;
         end
         drive_beat(p[b], n[b]);
         sum += beat_model(p[b], n[b]);
      end
      exp_q.push_back({trit_model(sum), SUM_W'(sum)});
   endtask

   task automatic wait_out(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (out_valid) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic take_out();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      tests_run++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_handshake: in_ready=%b out_valid=%b (required 0 0)", in_ready, out_valid);
      end
      tests_run++;
      if (out_sum !== '0 || out_trit !== 2'b00 || dbg_state !== 2'd0) begin
         tests_failed++;
         $display("FAIL reset_outputs: out_sum=%0d out_trit=%b state=%0d (required 0 00 0)",
                  out_sum, out_trit, dbg_state);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_release_ready: in_ready=%b (required 1)", in_ready);
      end
   endtask

   task automatic test_full_pos();
      logic [SUM_W+1:0] e;
      send_group('{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, '{default: 16'h0000}, 0);
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL latency_t1: out_valid=%b (required 0)", out_valid);
      end
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL latency_t2: out_valid=%b (required 1)", out_valid);
      end
      e = exp_q.pop_front();
      tests_run++;
      if (out_sum !== SUM_W'(64) || out_sum !== e[SUM_W-1:0] || out_trit !== 2'b01) begin
         tests_failed++;
         $display("FAIL full_pos: out_sum=%0d out_trit=%b (required 64 01)", out_sum, out_trit);
      end
      take_out();
   endtask

   task automatic test_neg_hold();
      logic [SUM_W+1:0] e;
      logic [SUM_W-1:0] s0;
      logic [1:0]       t0;
      bit               ok;
      send_group('{default: 16'h0000}, '{default: 16'h00FF}, 1);
      wait_out(ok);
      e = exp_q.pop_front();
      tests_run++;
      if (!ok || out_sum !== SUM_W'(-32) || out_sum !== e[SUM_W-1:0] || out_trit !== 2'b11) begin
         tests_failed++;
         $display("FAIL neg_sum: valid=%b out_sum=%0d out_trit=%b (required 1 -32 11)", ok, out_sum, out_trit);
      end
      s0 = out_sum;
      t0 = out_trit;
      in_valid = 1'b1;
      in_pos   = 16'hFFFF;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         tests_run++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== s0 || out_trit !== t0) begin
            tests_failed++;
            $display("FAIL hold_stable c%0d: out_valid=%b in_ready=%b out_sum=%0d out_trit=%b (required 1 0 %0d %b)",
                     c, out_valid, in_ready, out_sum, out_trit, $signed(s0), t0);
         end
      end
      in_valid = 1'b0;
      take_out();
      @(negedge clk);
      tests_run++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL after_handshake: in_ready=%b out_valid=%b (required 1 0)", in_ready, out_valid);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_boundary();
      logic [WIDTH-1:0] p0 [4] = '{16'h007F, 16'h00FF, 16'h0000, 16'h0000};
      logic [WIDTH-1:0] n0 [4] = '{16'h0000, 16'h0000, 16'h00FF, 16'h007F};
      logic [SUM_W+1:0] e;
      bit               ok;
      for (int c = 0; c < 4; c++) begin
         send_group('{p0[c], 16'h0000, 16'h0000, 16'h0000}, '{n0[c], 16'h0000, 16'h0000, 16'h0000}, 2);
         wait_out(ok);
         e = exp_q.pop_front();
         tests_run++;
         if (!ok || out_sum !== e[SUM_W-1:0] || out_trit !== e[SUM_W+1:SUM_W]) begin
            tests_failed++;
            $display("FAIL boundary c%0d: valid=%b out_sum=%0d out_trit=%b (required 1 %0d %b)",
                     c, ok, out_sum, out_trit, $signed(e[SUM_W-1:0]), e[SUM_W+1:SUM_W]);
         end
         take_out();
      end
   endtask

   task automatic test_reset_mid();
      logic [SUM_W+1:0] e;
      bit               ok;
      drive_beat(16'hFFFF, 16'h0000);
      drive_beat(16'hFFFF, 16'h0000);
      do_reset();
      send_group('{default: 16'h0001}, '{default: 16'h0000}, 1);
      wait_out(ok);
      e = exp_q.pop_front();
      tests_run++;
      if (!ok || out_sum !== e[SUM_W-1:0] || out_trit !== e[SUM_W+1:SUM_W]) begin
         tests_failed++;
         $display("FAIL reset_mid_group: valid=%b out_sum=%0d (required 1 %0d)", ok, out_sum, $signed(e[SUM_W-1:0]));
      end
      take_out();
      send_group('{default: 16'hFFFF}, '{default: 16'h0000}, 0);
      wait_out(ok);
      void'(exp_q.pop_front());
      @(negedge clk);
      rst = 1'b1;
      #1;
      tests_run++;
      if (out_valid !== 1'b0 || out_sum !== '0) begin
         tests_failed++;
         $display("FAIL reset_in_hold: out_valid=%b out_sum=%0d (required 0 0)", out_valid, out_sum);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      send_group('{default: 16'h0003}, '{default: 16'h0001}, 0);
      wait_out(ok);
      e = exp_q.pop_front();
      tests_run++;
      if (!ok || out_sum !== e[SUM_W-1:0]) begin
         tests_failed++;
         $display("FAIL after_hold_reset: valid=%b out_sum=%0d (required 1 %0d)", ok, out_sum, $signed(e[SUM_W-1:0]));
      end
      take_out();
   endtask

   task automatic test_approx();
      logic [SUM_W-1:0] want;
      bit               ok;
`ifdef POPCNT_APPROX_EN
      want = SUM_W'(16);
`else
      want = SUM_W'(12);
`endif
      send_group('{default: 16'h000F}, '{default: 16'h0001}, 0);
      wait_out(ok);
      void'(exp_q.pop_front());
      tests_run++;
      if (!ok || out_sum !== want) begin
         tests_failed++;
         $display("FAIL popcnt_mode_f: out_sum=%0d (required %0d)", out_sum, $signed(want));
      end
      take_out();
      send_group('{default: 16'h0007}, '{default: 16'h0001}, 0);
      wait_out(ok);
      void'(exp_q.pop_front());
      tests_run++;
      if (!ok || out_sum !== SUM_W'(8)) begin
         tests_failed++;
         $display("FAIL popcnt_mode_7: out_sum=%0d (required 8)", out_sum);
      end
      take_out();
   endtask

   task automatic test_random_throttle();
      int received;
      int cycles;
      received = 0;
      cycles   = 0;
      fork
         begin
            for (int g = 0; g < GROUPS; g++) begin
               beat_arr_t p, n;
               for (int b = 0; b < BEATS; b++) begin
                  p[b] = WIDTH'($urandom);
                  n[b] = WIDTH'($urandom);
               end
               if (abort) break;
               send_group(p, n, 2);
            end
         end
         begin
            logic [SUM_W+1:0] e;
            while (received < GROUPS && cycles < 60000 && !abort) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 3) != 0);
               @(negedge clk);
               cycles++;
               if (out_valid && out_ready) begin
                  received++;
                  tests_run++;
                  if (exp_q.size() == 0) begin
                     tests_failed++;
                     $display("FAIL rand_extra_group %0d: out_sum=%0d with no pending expectation", received, out_sum);
                  end else begin
                     e = exp_q.pop_front();
                     if (out_sum !== e[SUM_W-1:0] || out_trit !== e[SUM_W+1:SUM_W]) begin
                        tests_failed++;
                        $display("FAIL rand_group %0d: out_sum=%0d out_trit=%b (required %0d %b)",
                                 received, out_sum, out_trit, $signed(e[SUM_W-1:0]), e[SUM_W+1:SUM_W]);
                     end
                  end
               end
            end
            abort = 1'b1;
         end
      join
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      tests_run++;
      if (received != GROUPS || exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL rand_group_count: received=%0d pending=%0d (required %0d 0)", received, exp_q.size(), GROUPS);
      end
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_pos    = '0;
      in_neg    = '0;
      out_ready = 1'b0;
      thr_hi    = SUM_W'(THR_HI);
      thr_lo    = SUM_W'(THR_LO);
      test_reset();
      test_full_pos();
      test_neg_hold();
      test_boundary();
      test_reset_mid();
      test_approx();
      test_random_throttle();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
